// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed 7-seg scanner; in clk rst_n value_i load_i lz_en_i, out bin digit_sel_n blank frame_done
module sevenseg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic                  lz_en_i,
  output logic [3:0]            bin,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic                  blank,
  output logic                  frame_done
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] disp, shadow;
  logic pending, slot_end, frame_end, dark, acc;
  logic [DIGITS-1:0] zero_above;
  assign slot_end = cnt == CW'(DIV - 1);
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  always_comb begin
    zero_above = '0;
    acc = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc = acc & (disp[4*k +: 4] == 4'd0);
      zero_above[k] = acc;
    end
  end
  assign dark = 32'(cnt) < GUARD || (lz_en_i && idx != '0 && zero_above[idx]);
  assign bin = disp[4*idx +: 4];
  assign blank = dark;
  assign digit_sel_n = dark ? '1 : ~(DIGITS'(1) << idx);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      disp <= '0;
      shadow <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      frame_done <= frame_end;
      if (frame_end) begin
        disp <= load_i ? value_i : pending ? shadow : disp;
        pending <= 1'b0;
      end else if (load_i) begin
        shadow <= value_i;
        pending <= 1'b1;
      end
    end
  end
endmodule
